// File: rtl/seg7_scan_pkg.sv
// Shared constants for the 7-segment scan stage: glyph patterns, digit indices, FSM states.
package seg7_scan_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [2:0] IDX_SEC_DV    = 3'd0;
  localparam logic [2:0] IDX_SEC_CHUC  = 3'd1;
  localparam logic [2:0] IDX_MIN_DV    = 3'd2;
  localparam logic [2:0] IDX_MIN_CHUC  = 3'd3;
  localparam logic [2:0] IDX_HOUR_DV   = 3'd4;
  localparam logic [2:0] IDX_HOUR_CHUC = 3'd5;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [3:0] hour_chuc;
    logic [3:0] hour_dv;
    logic [3:0] min_chuc;
    logic [3:0] min_dv;
    logic [3:0] sec_chuc;
    logic [3:0] sec_dv;
  } digits_t;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high 7-segment pattern; non-decimal codes show a dash.
module seg7_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] pattern_c
);

  always_comb begin
    pattern_c = SEG_DASH;
    if (blank) begin
      pattern_c = SEG_OFF;
    end else begin
      case (bcd)
        4'd0:    pattern_c = SEG_0;
        4'd1:    pattern_c = SEG_1;
        4'd2:    pattern_c = SEG_2;
        4'd3:    pattern_c = SEG_3;
        4'd4:    pattern_c = SEG_4;
        4'd5:    pattern_c = SEG_5;
        4'd6:    pattern_c = SEG_6;
        4'd7:    pattern_c = SEG_7;
        4'd8:    pattern_c = SEG_8;
        4'd9:    pattern_c = SEG_9;
        default: pattern_c = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 6-digit 7-segment driver: input filter, per-frame snapshot, blanked scan, 1 Hz dp blink.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned BLANK_CYC   = 4,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          AN_ACT_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sec_dv,
  input  logic [3:0] sec_chuc,
  input  logic [3:0] min_dv,
  input  logic [3:0] min_chuc,
  input  logic [3:0] hour_dv,
  input  logic [3:0] hour_chuc,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int unsigned DIV  = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HALF = SCAN_HZ / 2;
  localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned CW   = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [6:0] SEG_IDLE = {7{SEG_ACT_LOW}};
  localparam logic [5:0] AN_IDLE  = {6{AN_ACT_LOW}};

  digits_t       raw_c, s1, s2, stable, snapshot;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic [CW-1:0] blank_cnt;
  logic [2:0]    idx;
  logic          blink;
  scan_state_e   state;

  logic          tick_c;
  logic [3:0]    digit_c;
  logic          lead_blank_c;
  logic [6:0]    pat_c;
  logic [5:0]    an_hot_c;
  logic          dp_on_c;

  assign raw_c  = {hour_chuc, hour_dv, min_chuc, min_dv, sec_chuc, sec_dv};
  assign tick_c = (presc == PW'(DIV - 1));

  // Digit currently selected out of the frame snapshot
  always_comb begin
    digit_c = snapshot.sec_dv;
    case (idx)
      IDX_SEC_CHUC:  digit_c = snapshot.sec_chuc;
      IDX_MIN_DV:    digit_c = snapshot.min_dv;
      IDX_MIN_CHUC:  digit_c = snapshot.min_chuc;
      IDX_HOUR_DV:   digit_c = snapshot.hour_dv;
      IDX_HOUR_CHUC: digit_c = snapshot.hour_chuc;
      default:       digit_c = snapshot.sec_dv;
    endcase
  end

  assign lead_blank_c = blank_lz && (idx == IDX_HOUR_CHUC) && (digit_c == 4'd0);
  assign an_hot_c     = 6'b000001 << idx;
  assign dp_on_c      = blink && ((idx == IDX_MIN_DV) || (idx == IDX_HOUR_DV));

  seg7_decode u_decode (
    .bcd       (digit_c),
    .blank     (lead_blank_c),
    .pattern_c (pat_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      stable    <= '0;
      snapshot  <= '0;
      presc     <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      blank_cnt <= '0;
      idx       <= IDX_SEC_DV;
      state     <= ST_BLANK;
      an        <= AN_IDLE;
      seg       <= SEG_IDLE;
      dp        <= SEG_ACT_LOW;
    end else begin
      // Accept the bus only once two consecutive samples agree
      s1 <= raw_c;
      s2 <= s1;
      if (s1 == s2) stable <= s2;

      presc <= tick_c ? '0 : presc + 1'b1;

      if (tick_c) begin
        if (blink_cnt == BW'(HALF - 1)) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      case (state)
        ST_BLANK: begin
          if (blank_cnt == CW'(BLANK_CYC - 1)) begin
            blank_cnt <= '0;
            state     <= ST_DRIVE;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (tick_c) begin
            state <= ST_BLANK;
            if (idx == IDX_HOUR_CHUC) begin
              idx      <= IDX_SEC_DV;
              snapshot <= stable;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: state <= ST_BLANK;
      endcase

      // Output stage follows the scan state one clock later
      if (state == ST_DRIVE) begin
        an  <= an_hot_c ^ AN_IDLE;
        seg <= pat_c ^ SEG_IDLE;
        dp  <= dp_on_c ^ SEG_ACT_LOW;
      end else begin
        an  <= AN_IDLE;
        seg <= SEG_IDLE;
        dp  <= SEG_ACT_LOW;
      end
    end
  end

endmodule
